// File: rtl/network_pkg.sv
`default_nettype none
// ============================================================================
// Module      : network_pkg
// Description : Shared FSM state encoding and saturation limits for the
//               network sample driver.
// Revision    : 1.0 - initial release
// ============================================================================
package network_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [15:0] c_SAT_POS_16 = 16'h7FFF;
    localparam logic [15:0] c_SAT_NEG_16 = 16'h8000;

    // Limits for an arbitrary width; callers truncate to their own width.
    function automatic logic [63:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_neg(input int w);
        return ~sat_pos(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_shift_left.sv
`default_nettype none
// ============================================================================
// Module      : sat_shift_left
// Description : Signed left shift by SHIFT bits, clamped to the W-bit range.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_shift_left
    import network_pkg::*;
#(
    parameter int W     = 16,
    parameter int SHIFT = 2
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int          c_EW  = W + SHIFT;
    localparam logic [W-1:0] c_POS = W'(sat_pos(W));
    localparam logic [W-1:0] c_NEG = W'(sat_neg(W));

    logic [c_EW-1:0] w_ext;
    logic [c_EW-1:0] w_shl;
    logic [SHIFT:0]  w_top;
    logic            w_fits;

    assign w_ext = c_EW'($signed(din));
    assign w_shl = w_ext << SHIFT;
    // The result fits only if every bit above the new sign bit repeats it.
    assign w_top  = w_shl[c_EW-1:W-1];
    assign w_fits = (w_top == '0) || (w_top == '1);
    assign dout   = w_fits ? w_shl[W-1:0] : (din[W-1] ? c_NEG : c_POS);

endmodule
`default_nettype wire

// File: rtl/network_sample_driver.sv
`default_nettype none
// ============================================================================
// Module      : network_sample_driver
// Description : Frames ADC samples into a network, waits its latency, and
//               captures saturated results for the DAC.
// Revision    : 1.0 - initial release
// ============================================================================
module network_sample_driver
    import network_pkg::*;
#(
    parameter int W           = 16,
    parameter int IN_SHIFT    = 2,
    parameter int OUT_SHIFT   = 2,
    parameter int CLK_HIGH    = 2,
    parameter int NET_LATENCY = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adc_strobe,
    input  logic [W-1:0] adc_in0,
    input  logic [W-1:0] adc_in1,
    input  logic [W-1:0] adc_in2,
    input  logic [W-1:0] adc_in3,
    output logic         sample_clk,
    output logic [W-1:0] sample_in0,
    output logic [W-1:0] sample_in1,
    output logic [W-1:0] sample_in2,
    output logic [W-1:0] sample_in3,
    input  logic [W-1:0] net_out0,
    input  logic [W-1:0] net_out1,
    input  logic [W-1:0] net_out2,
    input  logic [W-1:0] net_out3,
    output logic [W-1:0] dac_out0,
    output logic [W-1:0] dac_out1,
    output logic [W-1:0] dac_out2,
    output logic [W-1:0] dac_out3,
    output logic         dac_valid,
    output logic         busy,
    output logic [15:0]  overrun_count,
    output logic [15:0]  min_headroom
);

    localparam int c_CNT_MAX = (CLK_HIGH > NET_LATENCY) ? CLK_HIGH : NET_LATENCY;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LOAD = c_CNT_W'(CLK_HIGH - 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD  = c_CNT_W'(NET_LATENCY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_accept;
    logic               w_pulse_end;
    logic               w_capture;
    logic               w_drop;

    logic [W-1:0] w_adc       [4];
    logic [W-1:0] w_net       [4];
    logic [W-1:0] w_sat       [4];
    logic [W-1:0] r_sample_in [4];
    logic [W-1:0] r_dac_out   [4];

    logic         r_sample_clk;
    logic         r_dac_valid;
    logic         r_captured;
    logic [15:0]  r_overrun;
    logic [15:0]  r_idle_cnt;
    logic [15:0]  r_min_headroom;

    assign w_adc[0] = adc_in0;
    assign w_adc[1] = adc_in1;
    assign w_adc[2] = adc_in2;
    assign w_adc[3] = adc_in3;
    assign w_net[0] = net_out0;
    assign w_net[1] = net_out1;
    assign w_net[2] = net_out2;
    assign w_net[3] = net_out3;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sat
            sat_shift_left #(
                .W     (W),
                .SHIFT (OUT_SHIFT)
            ) u_sat (
                .din  (w_net[g]),
                .dout (w_sat[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_pulse_end = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (adc_strobe) begin
                    w_accept    = 1'b1;
                    w_state_nxt = PULSE;
                    w_cnt_nxt   = c_PULSE_LOAD;
                end
            end
            PULSE: begin
                if (r_cnt == '0) begin
                    w_pulse_end = 1'b1;
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = c_WAIT_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_drop = adc_strobe && (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sample_clk   <= 1'b0;
            r_dac_valid    <= 1'b0;
            r_captured     <= 1'b0;
            r_overrun      <= '0;
            r_idle_cnt     <= '0;
            r_min_headroom <= 16'hFFFF;
            for (int i = 0; i < 4; i++) begin
                r_sample_in[i] <= '0;
                r_dac_out[i]   <= '0;
            end
        end else begin
            r_dac_valid <= w_capture;

            if (w_accept) begin
                r_sample_clk <= 1'b1;
            end else if (w_pulse_end) begin
                r_sample_clk <= 1'b0;
            end

            if (w_accept) begin
                for (int i = 0; i < 4; i++) begin
                    r_sample_in[i] <= W'($signed(w_adc[i]) >>> IN_SHIFT);
                end
                // Headroom is only meaningful once a previous capture exists.
                if (r_captured && (r_idle_cnt < r_min_headroom)) begin
                    r_min_headroom <= r_idle_cnt;
                end
            end

            if (w_capture) begin
                for (int i = 0; i < 4; i++) begin
                    r_dac_out[i] <= w_sat[i];
                end
                r_captured <= 1'b1;
            end

            if (w_drop && (r_overrun != 16'hFFFF)) begin
                r_overrun <= r_overrun + 16'd1;
            end

            if (w_capture) begin
                r_idle_cnt <= '0;
            end else if ((r_state == IDLE) && (r_idle_cnt != 16'hFFFF)) begin
                r_idle_cnt <= r_idle_cnt + 16'd1;
            end
        end
    end

    assign sample_clk    = r_sample_clk;
    assign sample_in0    = r_sample_in[0];
    assign sample_in1    = r_sample_in[1];
    assign sample_in2    = r_sample_in[2];
    assign sample_in3    = r_sample_in[3];
    assign dac_out0      = r_dac_out[0];
    assign dac_out1      = r_dac_out[1];
    assign dac_out2      = r_dac_out[2];
    assign dac_out3      = r_dac_out[3];
    assign dac_valid     = r_dac_valid;
    assign busy          = (r_state != IDLE);
    assign overrun_count = r_overrun;
    assign min_headroom  = r_min_headroom;

endmodule
`default_nettype wire

// File: tb/tb_network_sample_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_network_sample_driver
// Description : Scoreboard bench for network_sample_driver (CLK_HIGH=2,
//               NET_LATENCY=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_network_sample_driver;

    localparam int c_CLK_HIGH    = 2;
    localparam int c_NET_LATENCY = 8;

    typedef struct packed {
        logic [3:0][15:0] d;
        int               cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        adc_strobe = 1'b0;
    logic [15:0] adc_in0 = '0, adc_in1 = '0, adc_in2 = '0, adc_in3 = '0;
    logic [15:0] net_out0 = '0, net_out1 = '0, net_out2 = '0, net_out3 = '0;
    logic        sample_clk;
    logic [15:0] sample_in0, sample_in1, sample_in2, sample_in3;
    logic [15:0] dac_out0, dac_out1, dac_out2, dac_out3;
    logic        dac_valid;
    logic        busy;
    logic [15:0] overrun_count;
    logic [15:0] min_headroom;

    int   n_cmp   = 0;
    int   n_err   = 0;
    int   n_push  = 0;
    int   n_valid = 0;
    int   cyc     = 0;
    int   exp_ovr = 0;
    exp_t sb[$];
    exp_t mon_e;

    network_sample_driver #(
        .W           (16),
        .IN_SHIFT    (2),
        .OUT_SHIFT   (2),
        .CLK_HIGH    (c_CLK_HIGH),
        .NET_LATENCY (c_NET_LATENCY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .adc_strobe    (adc_strobe),
        .adc_in0       (adc_in0),
        .adc_in1       (adc_in1),
        .adc_in2       (adc_in2),
        .adc_in3       (adc_in3),
        .sample_clk    (sample_clk),
        .sample_in0    (sample_in0),
        .sample_in1    (sample_in1),
        .sample_in2    (sample_in2),
        .sample_in3    (sample_in3),
        .net_out0      (net_out0),
        .net_out1      (net_out1),
        .net_out2      (net_out2),
        .net_out3      (net_out3),
        .dac_out0      (dac_out0),
        .dac_out1      (dac_out1),
        .dac_out2      (dac_out2),
        .dac_out3      (dac_out3),
        .dac_valid     (dac_valid),
        .busy          (busy),
        .overrun_count (overrun_count),
        .min_headroom  (min_headroom)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] exp_sat(input int v);
        int s;
        s = v * 4;
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    // Scoreboard: every dac_valid pops one predicted frame.
    always @(negedge clk) begin
        if (dac_valid) begin
            n_valid++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_dac_valid: dac_valid=1 at cycle %0d, required no output", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.cyc) begin
                    n_err++;
                    $display("FAIL dac_latency: dac_valid at cycle %0d, required cycle %0d", cyc, mon_e.cyc);
                end
                n_cmp++;
                if ({dac_out3, dac_out2, dac_out1, dac_out0} !== mon_e.d) begin
                    n_err++;
                    $display("FAIL dac_values: got %h %h %h %h, required %h %h %h %h",
                             dac_out0, dac_out1, dac_out2, dac_out3,
                             mon_e.d[0], mon_e.d[1], mon_e.d[2], mon_e.d[3]);
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b0;
        adc_strobe = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        exp_ovr = 0;
    endtask

    task automatic send_frame(input int a0, input int a1, input int a2, input int a3,
                              input int n0, input int n1, input int n2, input int n3,
                              input bit push);
        exp_t e;
        adc_in0 = 16'(a0); adc_in1 = 16'(a1); adc_in2 = 16'(a2); adc_in3 = 16'(a3);
        net_out0 = 16'(n0); net_out1 = 16'(n1); net_out2 = 16'(n2); net_out3 = 16'(n3);
        adc_strobe = 1'b1;
        if (push) begin
            e.d[0] = exp_sat(n0);
            e.d[1] = exp_sat(n1);
            e.d[2] = exp_sat(n2);
            e.d[3] = exp_sat(n3);
            e.cyc  = cyc + 2 + c_CLK_HIGH + c_NET_LATENCY;
            sb.push_back(e);
            n_push++;
        end
        @(negedge clk);
        adc_strobe = 1'b0;
    endtask

    task automatic drop_strobe(input int a);
        adc_in0 = 16'(a); adc_in1 = 16'(a); adc_in2 = 16'(a); adc_in3 = 16'(a);
        adc_strobe = 1'b1;
        exp_ovr++;
        @(negedge clk);
        adc_strobe = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int budget;
        budget = 200;
        while (busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: busy still 1 after 200 cycles, required 0", tag);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({sample_clk, dac_valid, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl: sample_clk/dac_valid/busy=%b, required 000", {sample_clk, dac_valid, busy});
        end
        n_cmp++;
        if ({sample_in0, dac_out0, overrun_count} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_data: sample_in0=%h dac_out0=%h overrun=%h, required 0", sample_in0, dac_out0, overrun_count);
        end
        n_cmp++;
        if (min_headroom !== 16'hFFFF) begin
            n_err++;
            $display("FAIL reset_headroom: got %h, required ffff", min_headroom);
        end
        rst = 1'b1;
    endtask

    task automatic test_nominal();
        int hi_cnt;
        hi_cnt = 0;
        send_frame(-400, 7, -7, -1, 1000, 3, -5, 0, 1'b1);
        n_cmp++;
        if ({sample_in0, sample_in1, sample_in2, sample_in3} !== {16'(-100), 16'd1, 16'(-2), 16'hFFFF}) begin
            n_err++;
            $display("FAIL nominal_sample_in: got %h %h %h %h, required ff9c 0001 fffe ffff",
                     sample_in0, sample_in1, sample_in2, sample_in3);
        end
        if (sample_clk) hi_cnt++;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (sample_clk) hi_cnt++;
            if (k == 4) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL nominal_busy: busy=%b in WAIT, required 1", busy);
                end
            end
        end
        n_cmp++;
        if (hi_cnt != c_CLK_HIGH) begin
            n_err++;
            $display("FAIL nominal_sample_clk_width: high %0d cycles, required %0d", hi_cnt, c_CLK_HIGH);
        end
        wait_done("nominal");
    endtask

    task automatic test_saturation();
        send_frame(0, 0, 0, 0, 16000, -9000, -1, 8191, 1'b1);
        wait_done("saturation");
        @(negedge clk);
    endtask

    task automatic test_overrun();
        send_frame(800, 0, 0, 0, 100, 200, 300, 400, 1'b1);
        repeat (4) @(negedge clk);
        drop_strobe(1234);
        repeat (4) @(negedge clk);
        drop_strobe(4321);
        n_cmp++;
        if (sample_in0 !== 16'd200) begin
            n_err++;
            $display("FAIL overrun_sample_stable: sample_in0=%h, required 00c8", sample_in0);
        end
        wait_done("overrun");
        repeat (3) @(negedge clk);
        n_cmp++;
        if (overrun_count !== 16'(exp_ovr)) begin
            n_err++;
            $display("FAIL overrun_count: got %0d, required %0d", overrun_count, exp_ovr);
        end
    endtask

    task automatic test_headroom();
        apply_reset();
        send_frame(4, 4, 4, 4, 1, 2, 3, 4, 1'b1);
        wait_done("headroom1");
        n_cmp++;
        if (min_headroom !== 16'hFFFF) begin
            n_err++;
            $display("FAIL headroom_first: got %h, required ffff", min_headroom);
        end
        repeat (20) @(negedge clk);
        send_frame(8, 8, 8, 8, 5, 6, 7, 8, 1'b1);
        n_cmp++;
        if (min_headroom !== 16'd20) begin
            n_err++;
            $display("FAIL headroom_20: got %0d, required 20", min_headroom);
        end
        wait_done("headroom2");
        repeat (15) @(negedge clk);
        send_frame(12, 12, 12, 12, -5, -6, -7, -8, 1'b1);
        n_cmp++;
        if (min_headroom !== 16'd15) begin
            n_err++;
            $display("FAIL headroom_15: got %0d, required 15", min_headroom);
        end
        wait_done("headroom3");
    endtask

    task automatic test_capture_strobe();
        @(negedge clk);
        send_frame(40, 40, 40, 40, 9, 9, 9, 9, 1'b1);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL capture_busy: busy=%b in CAPTURE cycle, required 1", busy);
        end
        drop_strobe(999);
        send_frame(-40, 0, 0, 0, -2, -3, 4, 5, 1'b1);
        n_cmp++;
        if ({min_headroom, overrun_count} !== {16'd0, 16'(exp_ovr)}) begin
            n_err++;
            $display("FAIL capture_next: headroom=%0d overrun=%0d, required 0 and %0d", min_headroom, overrun_count, exp_ovr);
        end
        n_cmp++;
        if (sample_in0 !== 16'(-10)) begin
            n_err++;
            $display("FAIL capture_next_sample: sample_in0=%h, required fff6", sample_in0);
        end
        wait_done("capture");
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        send_frame(100, 100, 100, 100, 50, 50, 50, 50, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_ovr = 0;
        n_cmp++;
        if ({sample_clk, busy, sample_in0, dac_out0, overrun_count} !== 50'h0) begin
            n_err++;
            $display("FAIL midreset_outputs: sample_clk=%b busy=%b sample_in0=%h dac_out0=%h overrun=%h, required 0",
                     sample_clk, busy, sample_in0, dac_out0, overrun_count);
        end
        n_cmp++;
        if (min_headroom !== 16'hFFFF) begin
            n_err++;
            $display("FAIL midreset_headroom: got %h, required ffff", min_headroom);
        end
        repeat (15) @(negedge clk);
        send_frame(-8, 0, 0, 0, 1000, -1000, 0, 1, 1'b1);
        n_cmp++;
        if (sample_in0 !== 16'(-2)) begin
            n_err++;
            $display("FAIL midreset_next_sample: sample_in0=%h, required fffe", sample_in0);
        end
        wait_done("midreset");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_overrun();
        test_headroom();
        test_capture_strobe();
        test_reset_mid_wait();
        n_cmp++;
        if (sb.size() != 0 || n_valid != n_push) begin
            n_err++;
            $display("FAIL frame_count: %0d dac_valid pulses with %0d pending, required %0d pulses and 0 pending",
                     n_valid, sb.size(), n_push);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
